// File: rtl/flex_pts_tx.sv
// Parallel-to-serial framed transmitter: start bit (0), NUM_BITS data bits, stop bit (1),
// each line bit held for CLKS_PER_BIT clocks; one word accepted per valid/ready handshake.
module flex_pts_tx #(
  parameter int unsigned NUM_BITS     = 8,
  parameter bit          SHIFT_MSB    = 1'b1,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_valid,
  input  logic [NUM_BITS-1:0] load_data,
  output logic                load_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                tx_done
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_BITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [NUM_BITS-1:0] shreg_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [CNT_W-1:0]    bit_q;
  logic                serial_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;

  logic [NUM_BITS-1:0] shifted_c;
  logic                head_c;
  logic                next_head_c;

  // Output-end bit now, the register after one shift, and the bit that shift exposes
  always_comb begin
    shifted_c   = shreg_q;
    head_c      = 1'b1;
    next_head_c = 1'b1;
    if (SHIFT_MSB) begin
      shifted_c   = {shreg_q[NUM_BITS-2:0], 1'b1};
      head_c      = shreg_q[NUM_BITS-1];
      next_head_c = shreg_q[NUM_BITS-2];
    end else begin
      shifted_c   = {1'b1, shreg_q[NUM_BITS-1:1]};
      head_c      = shreg_q[0];
      next_head_c = shreg_q[1];
    end
  end

  // Frame sequencer; line and status outputs are registered alongside the state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      tmr_q    <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q  <= load_data;
            tmr_q    <= '0;
            bit_q    <= '0;
            serial_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (tmr_q == TMR_LAST) begin
            tmr_q    <= '0;
            serial_q <= head_c;
            state_q  <= DATA;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        DATA: begin
          if (tmr_q == TMR_LAST) begin
            tmr_q   <= '0;
            shreg_q <= shifted_c;
            if (bit_q == BIT_LAST) begin
              bit_q    <= '0;
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bit_q    <= bit_q + CNT_W'(1);
              serial_q <= next_head_c;
            end
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        STOP: begin
          if (tmr_q == TMR_LAST) begin
            tmr_q    <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: begin
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule
